dma_stream_reader: RTL and testbench

- Downstream consumer of the DMA block and bridge into the FC datapath.
- Takes a job (base address, length in words) and splits it into DMA requests of at most BUFFER_SIZE words.
- Drives the DMA read/ready handshake and latches each filled DMA buffer.
- Streams the words one at a time on a valid/ready interface to the FC MAC stage, marking the final word of the job.

---
 rtl/dma_stream_pkg.sv | 25 ++
 rtl/dma_stream_reader_line_buffer.sv | 49 ++++
 rtl/dma_stream_reader.sv | 277 +++++++++++++++++++++++++++
 tb/tb_dma_stream_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dma_stream_pkg.sv
// Shared state encoding, width typedefs and chunk-sizing helpers for dma_stream_reader.
package dma_stream_pkg;

  localparam int unsigned DMA_ADDR_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t REQ     = 2'd1;
  localparam state_t RELEASE = 2'd2;
  localparam state_t STREAM  = 2'd3;

  typedef logic [DMA_ADDR_W-1:0] count_t;
  typedef logic [DMA_ADDR_W:0]   length_t;

  function automatic int unsigned min_chunk(input int unsigned remaining,
                                            input int unsigned buffer_size);
    return (remaining < buffer_size) ? remaining : buffer_size;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_stream_reader_line_buffer.sv
// Line buffer holding one DMA chunk: captures the first load_count words on load, word-indexed read.
module dma_line_buffer #(
  parameter int unsigned BUFFER_SIZE = 8,
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned COUNT_W     = 8,
  parameter int unsigned IDX_W       = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load,
  input  logic                            clear,
  input  logic [COUNT_W-1:0]              load_count,
  input  logic [BUFFER_SIZE*WORD_SIZE-1:0] load_data,
  input  logic [IDX_W-1:0]                read_index,
  output logic [WORD_SIZE-1:0]            read_data,
  output logic [COUNT_W-1:0]              count,
  output logic                            full,
  output logic                            empty
);

  logic [WORD_SIZE-1:0] words [BUFFER_SIZE];

  // Word 0 sits in the most-significant slice of the DMA buffer.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int unsigned i = 0; i < BUFFER_SIZE; i++) begin
        if (i < 32'(load_count)) begin
          words[i] <= load_data[(BUFFER_SIZE-1-i)*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full  <= 1'b0;
      count <= '0;
    end else if (load) begin
      full  <= 1'b1;
      count <= load_count;
    end else if (clear) begin
      full  <= 1'b0;
    end
  end

  assign empty     = ~full;
  assign read_data = words[read_index];

endmodule

// File: rtl/dma_stream_reader.sv
// Splits a job into DMA chunks and streams the words out on valid/ready.
// DMA_STREAM_PREFETCH_EN selects ping-pong line buffers with next-chunk prefetch.
module dma_stream_reader
  import dma_stream_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE       = 8,
  parameter int unsigned WORD_SIZE         = 16,
  parameter int unsigned MEM_ADDRESS_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_start,
  input  logic [MEM_ADDRESS_WIDTH-1:0]     i_base_address,
  input  logic [MEM_ADDRESS_WIDTH:0]       i_length,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_dma_read,
  output logic [MEM_ADDRESS_WIDTH-1:0]     o_dma_address,
  output logic [MEM_ADDRESS_WIDTH-1:0]     o_dma_count,
  input  logic [BUFFER_SIZE*WORD_SIZE-1:0] i_dma_buffer,
  input  logic                             i_dma_ready,
  output logic [WORD_SIZE-1:0]             o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic                             o_last
);

  localparam int unsigned AW    = MEM_ADDRESS_WIDTH;
  localparam int unsigned IDX_W = idx_width(BUFFER_SIZE);

  state_t               state;
  logic [AW-1:0]        cur_addr;
  logic [AW-1:0]        chunk;
  logic [AW:0]          remaining;
  logic [IDX_W-1:0]     rd_idx;
  logic                 busy;
  logic                 done;
  logic                 dma_read;
  logic                 valid;
  logic                 accept;
  logic                 chunk_end;
  logic [WORD_SIZE-1:0] word;

  function automatic logic [AW-1:0] chunk_of(input logic [AW:0] rem);
    return AW'(min_chunk(32'(rem), BUFFER_SIZE));
  endfunction

  assign accept        = valid && i_ready;
  assign o_valid       = valid;
  assign o_data        = valid ? word : '0;
  assign o_busy        = busy;
  assign o_done        = done;
  assign o_dma_read    = dma_read;
  assign o_dma_address = cur_addr;
  assign o_dma_count   = chunk;

`ifdef DMA_STREAM_PREFETCH_EN

  logic [AW-1:0]        line_count [2];
  logic [WORD_SIZE-1:0] line_word  [2];
  logic [1:0]           line_full;
  logic [1:0]           line_empty;
  logic [1:0]           load;
  logic [1:0]           clear;
  logic [1:0]           last_chunk;
  logic                 wr_sel;
  logic                 rd_sel;
  logic                 fetch_load;

  assign fetch_load = (state == REQ) && dma_read && i_dma_ready && line_empty[wr_sel];

  for (genvar b = 0; b < 2; b++) begin : g_line
    assign load[b]  = fetch_load && (wr_sel == 1'(b));
    assign clear[b] = accept && chunk_end && (rd_sel == 1'(b));

    dma_line_buffer #(
      .BUFFER_SIZE(BUFFER_SIZE),
      .WORD_SIZE  (WORD_SIZE),
      .COUNT_W    (AW),
      .IDX_W      (IDX_W)
    ) u_line (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[b]),
      .clear     (clear[b]),
      .load_count(chunk),
      .load_data (i_dma_buffer),
      .read_index(rd_idx),
      .read_data (line_word[b]),
      .count     (line_count[b]),
      .full      (line_full[b]),
      .empty     (line_empty[b])
    );
  end

  assign word      = line_word[rd_sel];
  assign valid     = busy && line_full[rd_sel];
  assign chunk_end = (AW'(rd_idx) == line_count[rd_sel] - AW'(1));
  assign o_last    = valid && chunk_end && last_chunk[rd_sel];

  // Fetch side walks REQ/RELEASE/STREAM independently; the stream side ends the job.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      chunk      <= '0;
      remaining  <= '0;
      rd_idx     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dma_read   <= 1'b0;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      last_chunk <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (i_length != '0) begin
              cur_addr  <= i_base_address;
              remaining <= i_length;
              chunk     <= chunk_of(i_length);
              dma_read  <= 1'b1;
              busy      <= 1'b1;
              wr_sel    <= 1'b0;
              rd_sel    <= 1'b0;
              rd_idx    <= '0;
              state     <= REQ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        REQ: begin
          if (fetch_load) begin
            last_chunk[wr_sel] <= ({1'b0, chunk} == remaining);
            dma_read  <= 1'b0;
            cur_addr  <= cur_addr + chunk;
            remaining <= remaining - {1'b0, chunk};
            wr_sel    <= ~wr_sel;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          if (!i_dma_ready) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if ((remaining != '0) && line_empty[wr_sel]) begin
            chunk    <= chunk_of(remaining);
            dma_read <= 1'b1;
            state    <= REQ;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        if (chunk_end) begin
          rd_idx <= '0;
          rd_sel <= ~rd_sel;
          if (last_chunk[rd_sel]) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            dma_read <= 1'b0;
            state    <= IDLE;
          end
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

`else

  logic [AW-1:0] line_count;
  logic          line_full;
  logic          line_empty;
  logic          load;
  logic          clear;

  assign load  = (state == REQ) && dma_read && i_dma_ready && line_empty;
  assign clear = accept && chunk_end;

  dma_line_buffer #(
    .BUFFER_SIZE(BUFFER_SIZE),
    .WORD_SIZE  (WORD_SIZE),
    .COUNT_W    (AW),
    .IDX_W      (IDX_W)
  ) u_line (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .clear     (clear),
    .load_count(chunk),
    .load_data (i_dma_buffer),
    .read_index(rd_idx),
    .read_data (word),
    .count     (line_count),
    .full      (line_full),
    .empty     (line_empty)
  );

  assign valid     = (state == STREAM) && line_full;
  assign chunk_end = (AW'(rd_idx) == line_count - AW'(1));
  assign o_last    = valid && chunk_end && (remaining == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      chunk     <= '0;
      remaining <= '0;
      rd_idx    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dma_read  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (i_length != '0) begin
              cur_addr  <= i_base_address;
              remaining <= i_length;
              chunk     <= chunk_of(i_length);
              dma_read  <= 1'b1;
              busy      <= 1'b1;
              state     <= REQ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        REQ: begin
          if (load) begin
            dma_read  <= 1'b0;
            cur_addr  <= cur_addr + chunk;
            remaining <= remaining - {1'b0, chunk};
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          if (!i_dma_ready) begin
            rd_idx <= '0;
            state  <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            if (chunk_end) begin
              rd_idx <= '0;
              if (remaining != '0) begin
                chunk    <= chunk_of(remaining);
                dma_read <= 1'b1;
                state    <= REQ;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_dma_stream_reader.sv
// Scoreboard bench for dma_stream_reader with a DMA model (memory word k = k, ready 3 cycles after read).
module tb_dma_stream_reader;
  import dma_stream_pkg::*;

  localparam int unsigned BS = 8;
  localparam int unsigned WS = 16;
  localparam int unsigned AW = 8;

  logic           clk            = 1'b0;
  logic           rst_n          = 1'b0;
  logic           i_start        = 1'b0;
  logic [AW-1:0]  i_base_address = '0;
  logic [AW:0]    i_length       = '0;
  logic           o_busy;
  logic           o_done;
  logic           o_dma_read;
  logic [AW-1:0]  o_dma_address;
  logic [AW-1:0]  o_dma_count;
  logic [BS*WS-1:0] i_dma_buffer = '0;
  logic           i_dma_ready    = 1'b0;
  logic [WS-1:0]  o_data;
  logic           o_valid;
  logic           i_ready        = 1'b0;
  logic           o_last;

  always #5 clk = ~clk;

  dma_stream_reader #(
    .BUFFER_SIZE      (BS),
    .WORD_SIZE        (WS),
    .MEM_ADDRESS_WIDTH(AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_base_address(i_base_address),
    .i_length      (i_length),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_dma_read    (o_dma_read),
    .o_dma_address (o_dma_address),
    .o_dma_count   (o_dma_count),
    .i_dma_buffer  (i_dma_buffer),
    .i_dma_ready   (i_dma_ready),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_last        (o_last)
  );

  typedef struct packed { count_t addr; count_t cnt; } req_t;
  typedef struct packed { logic [WS-1:0] data; logic last; } beat_t;

  req_t  req_q  [$];
  beat_t beat_q [$];

  int checks = 0;
  int failures = 0;

  int cyc = 0, phase = 0, ready_mode = 0;
  int dma_wait = 0, read_rises = 0, valid_seen = 0;
  int done_cnt = 0, done_cyc = 0, accept_cnt = 0, last_accept_cyc = 0;
  logic dma_read_q = 1'b0, stalled = 1'b0, stall_last = 1'b0;
  logic [WS-1:0] stall_data = '0;
  count_t req_addr = '0, req_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // DMA model, stream sink and scoreboard; outputs sampled mid-cycle.
  always @(negedge clk) begin
    req_t  rq;
    beat_t bt;
    cyc++;
    if (o_dma_read) begin
      if (!dma_read_q) begin
        read_rises++;
        req_addr = o_dma_address;
        req_cnt  = o_dma_count;
        dma_wait = 0;
        if (req_q.size() != 0) rq = req_q.pop_front();
        else rq = '1;
        chk("dma_request", {o_dma_address, o_dma_count}, rq);
      end else begin
        chk("dma_req_stable", {o_dma_address, o_dma_count}, {req_addr, req_cnt});
      end
      if (!i_dma_ready) begin
        dma_wait++;
        if (dma_wait == 3) begin
          for (int w = 0; w < int'(BS); w++) begin
            if (w < int'(req_cnt)) i_dma_buffer[(int'(BS)-1-w)*int'(WS) +: WS] = WS'(AW'(int'(req_addr) + w));
            else i_dma_buffer[(int'(BS)-1-w)*int'(WS) +: WS] = 16'hDEAD;
          end
          i_dma_ready = 1'b1;
        end
      end
    end else begin
      i_dma_ready = 1'b0;
    end
    dma_read_q = o_dma_read;

    i_ready = (ready_mode == 0) ? 1'b1 : ((phase % 3) == 0);
    phase++;
    if (stalled) begin
      chk("stall_valid", o_valid, 1);
      chk("stall_data", o_data, stall_data);
      chk("stall_last", o_last, stall_last);
    end
    stalled = 1'b0;
    if (o_valid) valid_seen++;
    if (o_valid && i_ready) begin
      if (beat_q.size() != 0) bt = beat_q.pop_front();
      else bt = '1;
      chk("stream_beat", {o_data, o_last}, bt);
      accept_cnt++;
      last_accept_cyc = cyc;
    end else if (o_valid) begin
      stalled    = 1'b1;
      stall_data = o_data;
      stall_last = o_last;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic expect_job(input int base, input int len);
    int a, rem, c;
    a = base;
    rem = len;
    req_q.delete();
    beat_q.delete();
    while (rem > 0) begin
      c = (rem < int'(BS)) ? rem : int'(BS);
      req_q.push_back({count_t'(a), count_t'(c)});
      for (int k = 0; k < c; k++) beat_q.push_back({WS'(AW'(a + k)), (k == c - 1) && (rem == c)});
      a = (a + c) % (1 << AW);
      rem -= c;
    end
  endtask

  task automatic issue(input int base, input int len);
    @(negedge clk); #1;
    i_base_address = AW'(base);
    i_length       = (AW+1)'(len);
    i_start        = 1'b1;
    @(negedge clk); #1;
    i_start        = 1'b0;
  endtask

  task automatic run_job(input int base, input int len, input int mode);
    int d0;
    bit got;
    d0 = done_cnt;
    got = 1'b0;
    ready_mode = mode;
    expect_job(base, len);
    issue(base, len);
    chk("busy_after_start", {o_busy, o_dma_read}, (len > 0) ? 2'b11 : 2'b00);
    if (len == 0) chk("zero_done_pulse", o_done, 1);
    for (int t = 0; t < 3000 && !got; t++) begin
      if (done_cnt != d0) got = 1'b1;
      else begin
        @(negedge clk); #1;
      end
    end
    chk("done_seen", got, 1);
    if (len > 0) chk("done_timing", done_cyc, last_accept_cyc + 1);
    chk("queues_drained", req_q.size() + beat_q.size(), 0);
    @(negedge clk); #1;
    chk("idle_after_job", {o_busy, o_done, o_valid, o_dma_read}, 0);
    chk("single_done", done_cnt, d0 + 1);
  endtask

  initial begin
    int r0, v0, d0, a0;
    bit reached;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", {o_busy, o_done, o_dma_read, o_valid, o_last}, 0);
    chk("reset_dma_bus", {o_dma_address, o_dma_count}, 0);
    chk("reset_data", o_data, 0);
    rst_n = 1'b1;

    run_job(1, 4, 0);
    run_job(0, 20, 0);
    run_job(0, 8, 1);

    r0 = read_rises;
    v0 = valid_seen;
    run_job(0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("zero_no_dma_read", read_rises, r0);
    chk("zero_no_valid", valid_seen, v0);

    run_job(250, 10, 0);

    // Abandon a job three words into the stream.
    d0 = done_cnt;
    a0 = accept_cnt;
    reached = 1'b0;
    ready_mode = 0;
    expect_job(0, 8);
    issue(0, 8);
    for (int t = 0; t < 200 && !reached; t++) begin
      if (accept_cnt >= a0 + 3) reached = 1'b1;
      else begin
        @(negedge clk); #1;
      end
    end
    chk("abort_reached_stream", reached, 1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("abort_ctrl", {o_busy, o_done, o_dma_read, o_valid, o_last}, 0);
    chk("abort_dma_bus", {o_dma_address, o_dma_count}, 0);
    chk("abort_data", o_data, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt, d0);
    rst_n = 1'b1;

    run_job(0, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
